unidade_controle_drone: RTL
===========================

UNIDADE_CONTROLE_DRONE -- requirements
Module: unidade_controle_drone

Interface
REQ-001 The block SHALL have these ports (clock and reset first):
- clock  in  1  single system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- iniciar  in  1  start/restart request, level
- confirma  in  1  menu confirm button, level (raw)
- borda_movimento  in  1  one-cycle movement pulse from datapath
- timeout  in  1  play-timer expired for the current mode
- colisao  in  1  collision count has reached the lives count
- fim_mapa  in  1  horizontal position == 15
- zeraPosicoes, resetaVidas, zeraT, contaT, desloca  out  1 each  datapath controls
- escolhe_modo, escolhe_vida, escolhe_mapa, checa_colisao, atualiza  out  1 each  datapath controls
- jogando  out  1  high in ESPERA, ATUALIZA, REGISTRA, AVALIA
- ganhou  out  1  high only in VENCEU
- perdeu  out  1  high only in PERDEU
- db_estado  out  4  current state code

Function
REQ-002 The block SHALL be a Moore FSM with registered state; all outputs SHALL decode from the current state only, except that the confirm pulse is internal.
REQ-003 Internal confirm pulse = confirma & ~confirma_q, where confirma_q is confirma registered one cycle; a held confirma SHALL produce exactly one pulse.
REQ-004 States, codes, and asserted outputs:
- INICIAL=0: none
- PREPARA=1: zeraPosicoes, resetaVidas, zeraT
- ESC_MODO=2: escolhe_modo
- ESC_VIDA=3: escolhe_vida
- ESC_MAPA=4: escolhe_mapa
- INICIA=5: zeraPosicoes, zeraT
- ESPERA=6: contaT, desloca
- ATUALIZA=7: atualiza
- REGISTRA=8: atualiza, checa_colisao
- AVALIA=9: zeraT
- VENCEU=10: ganhou
- PERDEU=11: perdeu
REQ-005 Transitions:
- INICIAL -> PREPARA when iniciar=1
- PREPARA -> ESC_MODO unconditionally
- ESC_MODO -> ESC_VIDA, ESC_VIDA -> ESC_MAPA, ESC_MAPA -> INICIA, each on a confirm pulse
- INICIA -> ESPERA unconditionally
- ESPERA: timeout -> PERDEU; else borda_movimento -> ATUALIZA; else stay
- ATUALIZA -> REGISTRA -> AVALIA, one cycle each
- AVALIA: colisao -> PERDEU; else fim_mapa -> VENCEU; else -> ESPERA
- VENCEU/PERDEU: iniciar=1 -> PREPARA; else stay
REQ-006 Simultaneous timeout and borda_movimento in ESPERA SHALL go to PERDEU. Simultaneous colisao and fim_mapa in AVALIA SHALL go to PERDEU.
REQ-007 A confirm pulse outside ESC_* states SHALL be ignored; the pulse generator SHALL still track confirma in every state.
REQ-008 desloca SHALL be high throughout ESPERA so that the same-cycle borda gating in the datapath moves the drone on the pulse cycle; the movement-to-evaluation latency SHALL be exactly 3 cycles (ATUALIZA, REGISTRA, AVALIA).
REQ-009 Unused state codes 12-15 SHALL transition to INICIAL on the next edge.

Reset
REQ-010 When reset=1 at a rising edge, state SHALL become INICIAL and confirma_q SHALL become 0, regardless of current state; all outputs SHALL then be 0 and db_estado SHALL be 0.
REQ-011 Reset asserted mid-game (any state) SHALL take effect on that edge, with no partial datapath pulse afterward.

Structure
REQ-012 State codes (4-bit) SHALL live in shared package drone_pkg, for reuse by the display/debug logic.
REQ-013 The confirm pulse SHALL use the existing edge_detector sub-module (reset tied to reset); there SHALL be no other sub-modules.

Verification
REQ-014 The bench SHALL cover these directed scenarios:
- Reset, then iniciar=1 for 1 cycle: db_estado sequence 0 -> 1 -> 2; in state 1 zeraPosicoes=resetaVidas=zeraT=1.
- In ESC_MODO, hold confirma high for 5 cycles: exactly one advance, to ESC_VIDA (3); a release and re-press then advances to 4, and another to 5 then 6.
- In ESPERA, pulse borda_movimento with colisao=0, fim_mapa=0: states 7, 8, 9, then 6; checa_colisao high only in 8.
- In ESPERA, assert timeout and borda_movimento on the same cycle: next state 11, perdeu=1.
- In AVALIA with colisao=1 and fim_mapa=1: state 11. With colisao=0 and fim_mapa=1: state 10, ganhou=1; then iniciar=1 gives state 1.
- Assert reset while in REGISTRA: next state 0, all outputs 0.

Source files
------------

// File: rtl/unidade_controle_drone_pkg.sv
// Shared state codes and control-word decode for the drone game controller.
// The display/debug logic reuses the 4-bit state codes from this package.
package drone_pkg;

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        PREPARA  = 4'd1,
        ESC_MODO = 4'd2,
        ESC_VIDA = 4'd3,
        ESC_MAPA = 4'd4,
        INICIA   = 4'd5,
        ESPERA   = 4'd6,
        ATUALIZA = 4'd7,
        REGISTRA = 4'd8,
        AVALIA   = 4'd9,
        VENCEU   = 4'd10,
        PERDEU   = 4'd11
    } estado_t;

    typedef struct packed {
        logic zeraPosicoes;
        logic resetaVidas;
        logic zeraT;
        logic contaT;
        logic desloca;
        logic escolhe_modo;
        logic escolhe_vida;
        logic escolhe_mapa;
        logic checa_colisao;
        logic atualiza;
        logic jogando;
        logic ganhou;
        logic perdeu;
    } ctrl_t;

    // Moore decode: the control word depends on the state alone.
    function automatic ctrl_t decodifica(estado_t e);
        ctrl_t c;
        c = '0;
        case (e)
            PREPARA: begin
                c.zeraPosicoes = 1'b1;
                c.resetaVidas  = 1'b1;
                c.zeraT        = 1'b1;
            end
            ESC_MODO: c.escolhe_modo = 1'b1;
            ESC_VIDA: c.escolhe_vida = 1'b1;
            ESC_MAPA: c.escolhe_mapa = 1'b1;
            INICIA: begin
                c.zeraPosicoes = 1'b1;
                c.zeraT        = 1'b1;
            end
            ESPERA: begin
                c.contaT  = 1'b1;
                c.desloca = 1'b1;
                c.jogando = 1'b1;
            end
            ATUALIZA: begin
                c.atualiza = 1'b1;
                c.jogando  = 1'b1;
            end
            REGISTRA: begin
                c.atualiza      = 1'b1;
                c.checa_colisao = 1'b1;
                c.jogando       = 1'b1;
            end
            AVALIA: begin
                c.zeraT   = 1'b1;
                c.jogando = 1'b1;
            end
            VENCEU:  c.ganhou = 1'b1;
            PERDEU:  c.perdeu = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/unidade_controle_drone_if.sv
// Control/status bundle between the drone controller (master) and its datapath (slave).
interface unidade_controle_drone_if;
    logic       iniciar;
    logic       confirma;
    logic       borda_movimento;
    logic       timeout;
    logic       colisao;
    logic       fim_mapa;
    logic       zeraPosicoes;
    logic       resetaVidas;
    logic       zeraT;
    logic       contaT;
    logic       desloca;
    logic       escolhe_modo;
    logic       escolhe_vida;
    logic       escolhe_mapa;
    logic       checa_colisao;
    logic       atualiza;
    logic       jogando;
    logic       ganhou;
    logic       perdeu;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, confirma, borda_movimento, timeout, colisao, fim_mapa,
        output zeraPosicoes, resetaVidas, zeraT, contaT, desloca,
               escolhe_modo, escolhe_vida, escolhe_mapa, checa_colisao, atualiza,
               jogando, ganhou, perdeu, db_estado
    );

    modport slave (
        output iniciar, confirma, borda_movimento, timeout, colisao, fim_mapa,
        input  zeraPosicoes, resetaVidas, zeraT, contaT, desloca,
               escolhe_modo, escolhe_vida, escolhe_mapa, checa_colisao, atualiza,
               jogando, ganhou, perdeu, db_estado
    );
endinterface

// File: rtl/unidade_controle_drone_edge_detector.sv
// Rising-edge detector: one-cycle pulse on each 0->1 transition of sinal.
module edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);
    logic sinal_d, sinal_q;

    always_comb sinal_d = sinal;

    always_ff @(posedge clock) begin
        if (reset) sinal_q <= 1'b0;
        else       sinal_q <= sinal_d;
    end

    assign pulso = sinal & ~sinal_q;
endmodule

// File: rtl/unidade_controle_drone.sv
// Moore FSM sequencing menu selection, movement evaluation and win/lose for the drone game.
// Outputs are registered alongside the state so they always match db_estado.
module unidade_controle_drone
    import drone_pkg::*;
(
    input logic                       clock,
    input logic                       reset,
    unidade_controle_drone_if.master  bus
);
    logic    confirma_pulso;
    estado_t estado_d, estado_q;
    ctrl_t   ctrl_d, ctrl_q;

    edge_detector u_confirma (
        .clock (clock),
        .reset (reset),
        .sinal (bus.confirma),
        .pulso (confirma_pulso)
    );

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL:  if (bus.iniciar) estado_d = PREPARA;
            PREPARA:  estado_d = ESC_MODO;
            ESC_MODO: if (confirma_pulso) estado_d = ESC_VIDA;
            ESC_VIDA: if (confirma_pulso) estado_d = ESC_MAPA;
            ESC_MAPA: if (confirma_pulso) estado_d = INICIA;
            INICIA:   estado_d = ESPERA;
            // Timeout wins over a movement pulse arriving on the same cycle.
            ESPERA: begin
                if (bus.timeout)              estado_d = PERDEU;
                else if (bus.borda_movimento) estado_d = ATUALIZA;
            end
            ATUALIZA: estado_d = REGISTRA;
            REGISTRA: estado_d = AVALIA;
            AVALIA: begin
                if (bus.colisao)       estado_d = PERDEU;
                else if (bus.fim_mapa) estado_d = VENCEU;
                else                   estado_d = ESPERA;
            end
            VENCEU, PERDEU: if (bus.iniciar) estado_d = PREPARA;
            default:  estado_d = INICIAL;
        endcase
        ctrl_d = decodifica(estado_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIAL;
            ctrl_q   <= '0;
        end else begin
            estado_q <= estado_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign bus.zeraPosicoes  = ctrl_q.zeraPosicoes;
    assign bus.resetaVidas   = ctrl_q.resetaVidas;
    assign bus.zeraT         = ctrl_q.zeraT;
    assign bus.contaT        = ctrl_q.contaT;
    assign bus.desloca       = ctrl_q.desloca;
    assign bus.escolhe_modo  = ctrl_q.escolhe_modo;
    assign bus.escolhe_vida  = ctrl_q.escolhe_vida;
    assign bus.escolhe_mapa  = ctrl_q.escolhe_mapa;
    assign bus.checa_colisao = ctrl_q.checa_colisao;
    assign bus.atualiza      = ctrl_q.atualiza;
    assign bus.jogando       = ctrl_q.jogando;
    assign bus.ganhou        = ctrl_q.ganhou;
    assign bus.perdeu        = ctrl_q.perdeu;
    assign bus.db_estado     = estado_q;
endmodule
